// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory pipeline stage: FSM encoding, timeout
// default, word-alignment helper and MEM/WB field widths.
package mem_stage_pkg;

    localparam int XLEN            = 32;
    localparam int REG_AW          = 5;
    localparam int WAIT_CNT_W      = 4;
    localparam int TIMEOUT_DEFAULT = 15;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } wait_state_e;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb & WORD_ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/mem_stage_wait_ctrl.sv
// Data-memory handshake controller: request/stall generation, ack wait
// counter with timeout, and the sticky bus error flag.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no request outstanding; an aligned access requests immediately
// ST_WAIT | request outstanding, waiting for dmem_ack or timeout
module mem_wait_ctrl
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic access_i,
    input  logic aligned_i,
    input  logic dmem_ack_i,
    output logic dmem_req_o,
    output logic stall_o,
    output logic timeout_o,
    output logic misalign_o,
    output logic bus_err_o
);

    localparam logic [WAIT_CNT_W:0] TMO_CNT = (WAIT_CNT_W+1)'(TIMEOUT);
    localparam logic [WAIT_CNT_W:0] CNT_ONE = (WAIT_CNT_W+1)'(1);

    wait_state_e           state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  bus_err_q, bus_err_d;
    logic [WAIT_CNT_W:0]   cnt_inc;

    // Timeout fires in the WAIT cycle whose increment would bring the count
    // to TIMEOUT, so the request (IDLE cycle included) stalls exactly TIMEOUT
    // cycles before it is forced to complete.
    assign cnt_inc = {1'b0, cnt_q} + CNT_ONE;

    // State, wait counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bus_err_d  = bus_err_q;
        dmem_req_o = 1'b0;
        stall_o    = 1'b0;
        timeout_o  = 1'b0;
        misalign_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access_i && aligned_i) begin
                    dmem_req_o = 1'b1;
                    if (!dmem_ack_i) begin
                        stall_o = 1'b1;
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end
                end else if (access_i) begin
                    misalign_o = 1'b1;
                end
            end
            ST_WAIT: begin
                dmem_req_o = 1'b1;
                if (dmem_ack_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_inc == TMO_CNT) begin
                    timeout_o = 1'b1;
                    bus_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    stall_o = 1'b1;
                    cnt_d   = cnt_inc[WAIT_CNT_W-1:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus_err_o = bus_err_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the data-memory port from EX/MEM, resolves
// branches, and holds the MEM/WB pipeline register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   branch_addr_reg,
    input  logic [XLEN-1:0]   alu_res_reg,
    input  logic [XLEN-1:0]   write_data_reg,
    input  logic [REG_AW-1:0] rd_reg,
    input  logic              zero_flag_reg,
    input  logic              mem_to_reg_reg,
    input  logic              reg_write_reg,
    input  logic              mem_read_reg,
    input  logic              mem_write_reg,
    input  logic              branch_reg,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_ack,
    output logic              pc_src,
    output logic [XLEN-1:0]   branch_target,
    output logic              stall,
    output logic              bus_err,
    output logic              misalign,
    output logic [XLEN-1:0]   mem_data_wb,
    output logic [XLEN-1:0]   alu_res_wb,
    output logic [REG_AW-1:0] rd_wb,
    output logic              mem_to_reg_wb,
    output logic              reg_write_wb
);

    logic access, aligned, timeout, ack_taken;

    logic [XLEN-1:0]   mem_data_q, mem_data_d;
    logic [XLEN-1:0]   alu_res_q, alu_res_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic              reg_write_q, reg_write_d;

    assign access  = mem_read_reg | mem_write_reg;
    assign aligned = is_word_aligned(alu_res_reg[1:0]);

    mem_wait_ctrl #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_ctrl (
        .clk        (clk),
        .rst        (rst),
        .access_i   (access),
        .aligned_i  (aligned),
        .dmem_ack_i (dmem_ack),
        .dmem_req_o (dmem_req),
        .stall_o    (stall),
        .timeout_o  (timeout),
        .misalign_o (misalign),
        .bus_err_o  (bus_err)
    );

    // An ack only counts while a request is actually on the bus.
    assign ack_taken = dmem_req & dmem_ack;

    assign dmem_addr     = alu_res_reg;
    assign dmem_wdata    = write_data_reg;
    assign dmem_we       = mem_write_reg;
    assign pc_src        = branch_reg & zero_flag_reg & ~stall;
    assign branch_target = branch_addr_reg;

    // MEM/WB next value: advance when not stalled, otherwise insert a bubble
    // while keeping the data fields.
    always_comb begin
        mem_data_d   = mem_data_q;
        alu_res_d    = alu_res_q;
        rd_d         = rd_q;
        mem_to_reg_d = mem_to_reg_q;
        reg_write_d  = reg_write_q;
        if (!stall) begin
            alu_res_d    = alu_res_reg;
            rd_d         = rd_reg;
            mem_to_reg_d = mem_to_reg_reg;
            reg_write_d  = reg_write_reg & ~misalign;
            if (ack_taken) begin
                mem_data_d = dmem_rdata;
            end else if (timeout) begin
                mem_data_d = '0;
            end
        end else begin
            mem_to_reg_d = 1'b0;
            reg_write_d  = 1'b0;
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_data_q   <= '0;
            alu_res_q    <= '0;
            rd_q         <= '0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
        end else begin
            mem_data_q   <= mem_data_d;
            alu_res_q    <= alu_res_d;
            rd_q         <= rd_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_write_q  <= reg_write_d;
        end
    end

    assign mem_data_wb   = mem_data_q;
    assign alu_res_wb    = alu_res_q;
    assign rd_wb         = rd_q;
    assign mem_to_reg_wb = mem_to_reg_q;
    assign reg_write_wb  = reg_write_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios followed by random operations,
// each checked against a per-operation transaction model of the stage.
module tb_mem_stage;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] branch_addr_reg, alu_res_reg, write_data_reg;
    logic [4:0]  rd_reg;
    logic        zero_flag_reg, mem_to_reg_reg, reg_write_reg;
    logic        mem_read_reg, mem_write_reg, branch_reg;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        stall, bus_err, misalign;
    logic [31:0] mem_data_wb, alu_res_wb;
    logic [4:0]  rd_wb;
    logic        mem_to_reg_wb, reg_write_wb;

    mem_stage #(.TIMEOUT(TMO)) dut (
        .clk             (clk),
        .rst             (rst),
        .branch_addr_reg (branch_addr_reg),
        .alu_res_reg     (alu_res_reg),
        .write_data_reg  (write_data_reg),
        .rd_reg          (rd_reg),
        .zero_flag_reg   (zero_flag_reg),
        .mem_to_reg_reg  (mem_to_reg_reg),
        .reg_write_reg   (reg_write_reg),
        .mem_read_reg    (mem_read_reg),
        .mem_write_reg   (mem_write_reg),
        .branch_reg      (branch_reg),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_rdata      (dmem_rdata),
        .dmem_ack        (dmem_ack),
        .pc_src          (pc_src),
        .branch_target   (branch_target),
        .stall           (stall),
        .bus_err         (bus_err),
        .misalign        (misalign),
        .mem_data_wb     (mem_data_wb),
        .alu_res_wb      (alu_res_wb),
        .rd_wb           (rd_wb),
        .mem_to_reg_wb   (mem_to_reg_wb),
        .reg_write_wb    (reg_write_wb)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Expected MEM/WB contents and sticky error, per transaction.
    logic [31:0] e_mdata, e_alu;
    logic [4:0]  e_rd;
    logic        e_m2r, e_rw, e_berr;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        branch_addr_reg = '0; alu_res_reg = '0; write_data_reg = '0; rd_reg = '0;
        zero_flag_reg = 1'b0; mem_to_reg_reg = 1'b0; reg_write_reg = 1'b0;
        mem_read_reg = 1'b0; mem_write_reg = 1'b0; branch_reg = 1'b0;
        dmem_rdata = '0; dmem_ack = 1'b0;
    endtask

    task automatic chk_wb(input string tag);
        chk32({tag, ".mem_data_wb"}, mem_data_wb, e_mdata);
        chk32({tag, ".alu_res_wb"}, alu_res_wb, e_alu);
        chk32({tag, ".rd_wb"}, {27'b0, rd_wb}, {27'b0, e_rd});
        chk1({tag, ".mem_to_reg_wb"}, mem_to_reg_wb, e_m2r);
        chk1({tag, ".reg_write_wb"}, reg_write_wb, e_rw);
        chk1({tag, ".bus_err"}, bus_err, e_berr);
    endtask

    // One instruction through MEM. The memory acks in cycle 'delay' (0 = same
    // cycle as the request); a request lasting TMO cycles without ack times out.
    task automatic run_op(input string tag, input logic rd_en, input logic wr_en,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int delay,
                          input logic [4:0] rd, input logic m2r, input logic rw,
                          input logic br, input logic zf, input logic [31:0] baddr);
        logic acc, alg, req, st, acked, timed;
        alu_res_reg = addr; write_data_reg = wdata; dmem_rdata = rdata; rd_reg = rd;
        mem_read_reg = rd_en; mem_write_reg = wr_en; mem_to_reg_reg = m2r;
        reg_write_reg = rw; branch_reg = br; zero_flag_reg = zf; branch_addr_reg = baddr;
        acc = rd_en | wr_en;
        alg = (addr % 4) == 0;
        req = acc && alg;
        for (int k = 0; k <= TMO; k++) begin
            acked = req && (k == delay);
            timed = req && !acked && (k == TMO);
            st    = req && !acked && !timed;
            dmem_ack = req ? (k == delay) : 1'($urandom_range(0, 1));
            #1;
            chk1({tag, ".dmem_req"}, dmem_req, req);
            chk1({tag, ".dmem_we"}, dmem_we, wr_en);
            chk32({tag, ".dmem_addr"}, dmem_addr, addr);
            chk32({tag, ".dmem_wdata"}, dmem_wdata, wdata);
            chk1({tag, ".stall"}, stall, st);
            chk1({tag, ".misalign"}, misalign, acc && !alg && (k == 0));
            chk1({tag, ".pc_src"}, pc_src, br && zf && !st);
            chk32({tag, ".branch_target"}, branch_target, baddr);
            @(posedge clk); #1;
            if (st) begin
                e_rw = 1'b0; e_m2r = 1'b0;
            end else begin
                e_alu = addr; e_rd = rd; e_m2r = m2r;
                e_rw  = rw && !(acc && !alg);
                if (acked) e_mdata = rdata;
                else if (timed) begin e_mdata = '0; e_berr = 1'b1; end
            end
            chk_wb(tag);
            if (!st) break;
        end
        dmem_ack = 1'b0;
    endtask

    task automatic model_reset();
        e_mdata = '0; e_alu = '0; e_rd = '0; e_m2r = 1'b0; e_rw = 1'b0; e_berr = 1'b0;
    endtask

    initial begin
        logic [31:0] r_addr, r_wd, r_rd, r_ba;
        logic [1:0]  r_kind;
        int          r_dly;

        // Reset
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        #1;
        chk1("reset.dmem_req", dmem_req, 1'b0);
        chk1("reset.stall", stall, 1'b0);
        chk1("reset.misalign", misalign, 1'b0);
        chk1("reset.pc_src", pc_src, 1'b0);
        chk32("reset.dmem_addr", dmem_addr, 32'h0);
        chk_wb("reset");
        @(posedge clk); #1;

        // Zero-wait load
        run_op("load0", 1, 0, 32'h40, 32'h0, 32'hDEADBEEF, 0, 5'd3, 1, 1, 0, 0, 32'h0);
        chk32("load0.data", mem_data_wb, 32'hDEADBEEF);
        // Store acked on third cycle
        run_op("store3", 0, 1, 32'h80, 32'h12345678, 32'h0BAD0BAD, 2, 5'd0, 0, 0, 0, 0, 32'h0);
        // Misaligned load
        run_op("misal", 1, 0, 32'h42, 32'h0, 32'h55555555, 0, 5'd7, 1, 1, 0, 0, 32'h0);
        // Branch taken / not taken
        run_op("br_t", 0, 0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 0, 0, 1, 1, 32'h100);
        run_op("br_nt", 0, 0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 0, 0, 1, 0, 32'h100);
        // Branch alongside a stalled load: pc_src held off while stalling
        run_op("br_stall", 1, 0, 32'h44, 32'h0, 32'hCAFEF00D, 1, 5'd9, 1, 1, 1, 1, 32'h200);
        // Read+write together: write wins
        run_op("both", 1, 1, 32'hC0, 32'hA5A5A5A5, 32'h11112222, 0, 5'd4, 0, 1, 0, 0, 32'h0);

        // Random traffic, no timeouts
        for (int i = 0; i < 60; i++) begin
            r_addr = $urandom();
            if ($urandom_range(0, 4) != 0) r_addr = r_addr & 32'hFFFF_FFFC;
            r_wd = $urandom(); r_rd = $urandom(); r_ba = $urandom();
            r_kind = 2'($urandom_range(0, 3));
            r_dly = $urandom_range(0, 4);
            run_op("rand", r_kind[0], r_kind[1], r_addr, r_wd, r_rd, r_dly,
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), r_ba);
        end

        // Ack on the very last allowed cycle still wins over timeout
        run_op("ack_last", 1, 0, 32'h48, 32'h0, 32'h77778888, TMO, 5'd5, 1, 1, 0, 0, 32'h0);
        // Timeout: ack never arrives
        run_op("tmo", 1, 0, 32'h60, 32'h0, 32'hFFFFFFFF, 1000, 5'd6, 1, 1, 0, 0, 32'h0);
        chk32("tmo.data", mem_data_wb, 32'h0);
        chk1("tmo.bus_err", bus_err, 1'b1);
        // bus_err is sticky
        run_op("after_tmo", 1, 0, 32'h64, 32'h0, 32'h13579BDF, 0, 5'd8, 1, 1, 0, 0, 32'h0);
        run_op("after_tmo2", 0, 1, 32'h68, 32'h2468ACE0, 32'h0, 1, 5'd0, 0, 0, 0, 0, 32'h0);

        // Reset in the second WAIT cycle, then a late ack
        clear_inputs();
        alu_res_reg = 32'h70; mem_read_reg = 1'b1; mem_to_reg_reg = 1'b1;
        reg_write_reg = 1'b1; rd_reg = 5'd11; dmem_rdata = 32'h99999999;
        for (int k = 0; k < 2; k++) begin
            #1 chk1("rstw.stall", stall, 1'b1);
            @(posedge clk); #1;
            e_rw = 1'b0; e_m2r = 1'b0;
            chk_wb("rstw.bubble");
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_inputs();
        dmem_ack = 1'b1;
        dmem_rdata = 32'h99999999;
        model_reset();
        #1;
        chk1("rstw.dmem_req", dmem_req, 1'b0);
        chk1("rstw.stall", stall, 1'b0);
        chk1("rstw.misalign", misalign, 1'b0);
        chk1("rstw.pc_src", pc_src, 1'b0);
        chk_wb("rstw.cleared");
        @(posedge clk); #1;
        chk_wb("rstw.late_ack");
        dmem_ack = 1'b0;

        // Normal operation resumes
        run_op("resume", 1, 0, 32'h74, 32'h0, 32'h31415926, 0, 5'd12, 1, 1, 0, 0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
